// File: rtl/bpu_gshare.sv
// Gshare branch predictor: direct-mapped BTB, global-history-indexed PHT of
// saturating counters, and a circular return address stack.
module bpu_gshare #(
    parameter int PC_SIZE    = 32,
    parameter int TABLE_SIZE = 512,
    parameter int CNT_BITS   = 2,
    parameter int GHR_BITS   = 9,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                f_valid,
    input  logic [PC_SIZE-1:0]  f_pc,
    input  logic                f_is_br,
    input  logic                f_is_jal,
    input  logic                f_is_call,
    input  logic                f_is_ret,

    output logic                pred_taken,
    output logic [PC_SIZE-1:0]  pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,

    input  logic                r_valid,
    input  logic [PC_SIZE-1:0]  r_pc,
    input  logic                r_is_br,
    input  logic                r_taken,
    input  logic [PC_SIZE-1:0]  r_target,
    input  logic                r_pred_taken,
    input  logic [PC_SIZE-1:0]  r_pred_target,
    input  logic [GHR_BITS-1:0] r_ghr,

    output logic                flush,
    output logic [PC_SIZE-1:0]  redirect_pc
);

    localparam int IDX    = $clog2(TABLE_SIZE);
    localparam int TAG    = PC_SIZE - IDX - 2;
    localparam int RAS_PW = $clog2(RAS_DEPTH);

    localparam logic [CNT_BITS-1:0] CNT_INIT  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [RAS_PW:0]     RAS_FULL  = (RAS_PW + 1)'(RAS_DEPTH);

    logic                btb_valid  [TABLE_SIZE];
    logic [TAG-1:0]      btb_tag    [TABLE_SIZE];
    logic [PC_SIZE-1:0]  btb_target [TABLE_SIZE];
    logic [CNT_BITS-1:0] pht        [TABLE_SIZE];

    logic [PC_SIZE-1:0]  ras        [RAS_DEPTH];
    logic [RAS_PW-1:0]   ras_ptr;
    logic [RAS_PW:0]     ras_count;

    logic [GHR_BITS-1:0] ghr;

    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] hist,
                                                     input logic bit_in);
        logic [GHR_BITS:0] wide;
        wide = {hist, bit_in};
        return wide[GHR_BITS-1:0];
    endfunction

    logic [IDX-1:0]      f_idx;
    logic [TAG-1:0]      f_tag;
    logic                f_hit;
    logic [PC_SIZE-1:0]  f_seq;
    logic [PC_SIZE-1:0]  f_btb_target;
    logic [IDX-1:0]      ghr_ext;
    logic [IDX-1:0]      f_pht_idx;
    logic [CNT_BITS-1:0] f_cnt;
    logic [RAS_PW-1:0]   ras_top_ptr;
    logic [PC_SIZE-1:0]  ras_top;
    logic                ras_nonempty;

    always_comb begin
        ghr_ext                = '0;
        ghr_ext[GHR_BITS-1:0]  = ghr;
    end

    assign f_idx        = f_pc[IDX+1:2];
    assign f_tag        = f_pc[PC_SIZE-1:IDX+2];
    assign f_hit        = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_seq        = f_pc + PC_SIZE'(4);
    assign f_btb_target = f_hit ? btb_target[f_idx] : f_seq;
    assign f_pht_idx    = f_idx ^ ghr_ext;
    assign f_cnt        = pht[f_pht_idx];
    assign ras_top_ptr  = ras_ptr - RAS_PW'(1);
    assign ras_top      = ras[ras_top_ptr];
    assign ras_nonempty = (ras_count != '0);

    // A BTB miss yields the sequential PC as target, so a cold entry never redirects.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = f_seq;
        if (f_valid) begin
            if (f_is_ret && ras_nonempty) begin
                pred_taken  = 1'b1;
                pred_target = ras_top;
            end else if (f_is_ret || f_is_jal || f_is_call) begin
                pred_taken  = f_hit;
                pred_target = f_btb_target;
            end else if (f_is_br) begin
                pred_taken  = f_hit && f_cnt[CNT_BITS-1];
                pred_target = f_btb_target;
            end
        end
    end

    assign pred_ghr = ghr;

    logic [IDX-1:0]      r_idx;
    logic [TAG-1:0]      r_tag;
    logic [IDX-1:0]      r_ghr_ext;
    logic [IDX-1:0]      r_pht_idx;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] r_cnt_next;
    logic                mispredict;

    always_comb begin
        r_ghr_ext               = '0;
        r_ghr_ext[GHR_BITS-1:0] = r_ghr;
    end

    assign r_idx     = r_pc[IDX+1:2];
    assign r_tag     = r_pc[PC_SIZE-1:IDX+2];
    assign r_pht_idx = r_idx ^ r_ghr_ext;
    assign r_cnt     = pht[r_pht_idx];

    always_comb begin
        r_cnt_next = r_cnt;
        if (r_taken) begin
            if (r_cnt != CNT_MAX) r_cnt_next = r_cnt + CNT_BITS'(1);
        end else begin
            if (r_cnt != '0) r_cnt_next = r_cnt - CNT_BITS'(1);
        end
    end

    assign mispredict = r_valid &&
                        ((r_taken != r_pred_taken) ||
                         (r_taken && (r_target != r_pred_target)));

    // Table writes land at the edge; fetch reads above always see pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                pht[i]        <= CNT_INIT;
            end
        end else begin
            if (r_valid && r_taken) begin
                btb_valid[r_idx]  <= 1'b1;
                btb_tag[r_idx]    <= r_tag;
                btb_target[r_idx] <= r_target;
            end
            if (r_valid && r_is_br) begin
                pht[r_pht_idx] <= r_cnt_next;
            end
        end
    end

    // Pop is applied before push, so call+ret rewrites the current top in place.
    logic              do_pop;
    logic              do_push;
    logic [RAS_PW-1:0] pop_ptr;
    logic [RAS_PW:0]   pop_count;
    logic [RAS_PW-1:0] ras_ptr_next;
    logic [RAS_PW:0]   ras_count_next;

    assign do_pop  = f_valid && f_is_ret && ras_nonempty;
    assign do_push = f_valid && f_is_call;

    always_comb begin
        pop_ptr        = do_pop ? ras_top_ptr : ras_ptr;
        pop_count      = do_pop ? (ras_count - (RAS_PW + 1)'(1)) : ras_count;
        ras_ptr_next   = pop_ptr;
        ras_count_next = pop_count;
        if (do_push) begin
            ras_ptr_next = pop_ptr + RAS_PW'(1);
            if (pop_count != RAS_FULL) ras_count_next = pop_count + (RAS_PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
            ras_ptr   <= '0;
            ras_count <= '0;
        end else begin
            if (do_push) begin
                ras[pop_ptr] <= f_seq;
            end
            ras_ptr   <= ras_ptr_next;
            ras_count <= ras_count_next;
        end
    end

    // Resolve-time history repair outranks the speculative fetch shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr         <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            if (mispredict) begin
                ghr <= r_is_br ? shift_in(r_ghr, r_taken) : r_ghr;
            end else if (f_valid && f_is_br) begin
                ghr <= shift_in(ghr, pred_taken);
            end
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= r_taken ? r_target : (r_pc + PC_SIZE'(4));
            end
        end
    end

endmodule

// File: tb/tb_bpu_gshare.sv
// Scoreboard bench for bpu_gshare: directed fetch/resolve vectors push expected
// responses; a negedge monitor pops and compares them.
module tb_bpu_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        f_is_br, f_is_jal, f_is_call, f_is_ret;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [8:0]  pred_ghr;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_is_br, r_taken;
    logic [31:0] r_target;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic [8:0]  r_ghr;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    bpu_gshare dut (
        .clk           (clk),
        .rst           (rst),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .f_is_br       (f_is_br),
        .f_is_jal      (f_is_jal),
        .f_is_call     (f_is_call),
        .f_is_ret      (f_is_ret),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_ghr      (pred_ghr),
        .r_valid       (r_valid),
        .r_pc          (r_pc),
        .r_is_br       (r_is_br),
        .r_taken       (r_taken),
        .r_target      (r_target),
        .r_pred_taken  (r_pred_taken),
        .r_pred_target (r_pred_target),
        .r_ghr         (r_ghr),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [8:0]  ghr;
    } pred_exp_t;

    typedef struct {
        logic        fl;
        logic [31:0] redirect;
    } state_exp_t;

    pred_exp_t   pred_q[$];
    logic [31:0] flush_q[$];
    state_exp_t  state_q[$];
    pred_exp_t   mon_pred;
    state_exp_t  mon_state;
    logic [31:0] mon_redirect;
    logic        chk_state = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (f_valid === 1'b1) begin
            if (pred_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL pred_unexpected actual=lookup required=none");
            end else begin
                mon_pred = pred_q.pop_front();
                checkOutput("pred_taken",  {31'b0, pred_taken}, {31'b0, mon_pred.taken});
                checkOutput("pred_target", pred_target, mon_pred.target);
                checkOutput("pred_ghr",    {23'b0, pred_ghr}, {23'b0, mon_pred.ghr});
            end
        end
        if (flush === 1'b1) begin
            if (flush_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL flush_unexpected actual=1 required=0 redirect=0x%0h", redirect_pc);
            end else begin
                mon_redirect = flush_q.pop_front();
                checkOutput("redirect_pc", redirect_pc, mon_redirect);
            end
        end
        if (chk_state && state_q.size() != 0) begin
            mon_state = state_q.pop_front();
            checkOutput("state_flush",    {31'b0, flush}, {31'b0, mon_state.fl});
            checkOutput("state_redirect", redirect_pc, mon_state.redirect);
        end
    end

    task automatic idle_inputs();
        f_valid = 0; f_pc = '0; f_is_br = 0; f_is_jal = 0; f_is_call = 0; f_is_ret = 0;
        r_valid = 0; r_pc = '0; r_is_br = 0; r_taken = 0; r_target = '0;
        r_pred_taken = 0; r_pred_target = '0; r_ghr = '0;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic br, input logic jal,
                             input logic call, input logic ret);
        f_valid = 1; f_pc = pc; f_is_br = br; f_is_jal = jal; f_is_call = call; f_is_ret = ret;
    endtask

    task automatic set_resolve(input logic [31:0] pc, input logic is_br, input logic taken,
                               input logic [31:0] target, input logic ptaken,
                               input logic [31:0] ptarget, input logic [8:0] g);
        r_valid = 1; r_pc = pc; r_is_br = is_br; r_taken = taken; r_target = target;
        r_pred_taken = ptaken; r_pred_target = ptarget; r_ghr = g;
    endtask

    task automatic expect_pred(input logic taken, input logic [31:0] target, input logic [8:0] g);
        pred_exp_t e;
        e.taken = taken; e.target = target; e.ghr = g;
        pred_q.push_back(e);
    endtask

    task automatic expect_flush(input logic [31:0] redirect);
        flush_q.push_back(redirect);
    endtask

    task automatic expect_state(input logic fl, input logic [31:0] redirect);
        state_exp_t e;
        e.fl = fl; e.redirect = redirect;
        state_q.push_back(e);
        chk_state = 1'b1;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        idle_inputs();
        chk_state = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold lookup right after reset
        expect_state(1'b0, 32'h0);
        set_fetch(32'h100, 1, 0, 0, 0); expect_pred(0, 32'h104, 9'd0); applyStimulus();

        // First taken resolve mispredicts and trains the BTB
        set_resolve(32'h100, 1, 1, 32'h200, 0, 32'h104, 9'd0); expect_flush(32'h200); applyStimulus();
        set_fetch(32'h300, 0, 0, 0, 0); expect_pred(0, 32'h304, 9'd1); applyStimulus();

        set_resolve(32'h100, 1, 1, 32'h200, 1, 32'h200, 9'd0); applyStimulus();
        set_resolve(32'h100, 1, 1, 32'h200, 1, 32'h200, 9'd0); applyStimulus();
        // Non-branch mispredict restores GHR to the echoed value 0
        set_resolve(32'h500, 0, 0, 32'h0, 1, 32'h600, 9'd0); expect_flush(32'h504); applyStimulus();
        set_fetch(32'h100, 1, 0, 0, 0); expect_pred(1, 32'h200, 9'd0); applyStimulus();
        set_fetch(32'h100, 1, 0, 0, 0); expect_pred(0, 32'h200, 9'd1); applyStimulus();

        // Aliasing on BTB index 64
        set_fetch(32'h900, 0, 1, 0, 0); expect_pred(0, 32'h904, 9'd2); applyStimulus();
        set_resolve(32'h900, 0, 1, 32'hA00, 1, 32'hA00, 9'd2); applyStimulus();
        set_fetch(32'h100, 0, 1, 0, 0); expect_pred(0, 32'h104, 9'd2); applyStimulus();
        set_fetch(32'h900, 0, 1, 0, 0); expect_pred(1, 32'hA00, 9'd2); applyStimulus();

        // RAS overflow then drain
        for (int k = 1; k <= 9; k++) begin
            set_fetch(32'(k * 16), 0, 0, 1, 0); expect_pred(0, 32'(k * 16 + 4), 9'd2); applyStimulus();
        end
        for (int k = 0; k < 8; k++) begin
            set_fetch(32'h1000, 0, 0, 0, 1); expect_pred(1, 32'(148 - k * 16), 9'd2); applyStimulus();
        end
        set_fetch(32'h1000, 0, 0, 0, 1); expect_pred(0, 32'h1004, 9'd2); applyStimulus();

        // Combined call+ret replaces the top
        set_fetch(32'h40, 0, 0, 1, 0); expect_pred(0, 32'h44, 9'd2); applyStimulus();
        set_fetch(32'h50, 0, 0, 1, 1); expect_pred(1, 32'h44, 9'd2); applyStimulus();
        set_fetch(32'h1000, 0, 0, 0, 1); expect_pred(1, 32'h54, 9'd2); applyStimulus();
        set_fetch(32'h1000, 0, 0, 0, 1); expect_pred(0, 32'h1004, 9'd2); applyStimulus();

        // Same-entry fetch and resolve: read sees the old entry
        set_fetch(32'h800, 0, 1, 0, 0); expect_pred(0, 32'h804, 9'd2);
        set_resolve(32'h800, 0, 1, 32'h880, 1, 32'h880, 9'd2); applyStimulus();
        set_fetch(32'h800, 0, 1, 0, 0); expect_pred(1, 32'h880, 9'd2); applyStimulus();

        // Counter saturation at 0, then climb to weak taken on PHT index 66
        set_resolve(32'h100, 1, 0, 32'h0, 0, 32'h104, 9'd2); applyStimulus();
        set_resolve(32'h100, 1, 0, 32'h0, 0, 32'h104, 9'd2); applyStimulus();
        set_resolve(32'h100, 1, 1, 32'h200, 1, 32'h200, 9'd2); applyStimulus();
        set_resolve(32'h100, 1, 1, 32'h200, 1, 32'h200, 9'd2); applyStimulus();
        set_fetch(32'h100, 1, 0, 0, 0); expect_pred(1, 32'h200, 9'd2); applyStimulus();

        // Reset while flush is high, a push is in flight and a resolve is pending
        set_resolve(32'h600, 1, 0, 32'h0, 1, 32'h680, 9'd5); expect_flush(32'h604); applyStimulus();
        rst = 1'b1;
        set_fetch(32'h700, 0, 0, 1, 0); expect_pred(0, 32'h704, 9'd10);
        set_resolve(32'h100, 1, 1, 32'h300, 0, 32'h104, 9'd10); applyStimulus();
        rst = 1'b0;
        expect_state(1'b0, 32'h0);
        set_fetch(32'h100, 0, 0, 0, 1); expect_pred(0, 32'h104, 9'd0); applyStimulus();

        repeat (3) applyStimulus();
        checkOutput("pred_q_left",  32'(pred_q.size()),  32'd0);
        checkOutput("flush_q_left", 32'(flush_q.size()), 32'd0);
        checkOutput("state_q_left", 32'(state_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
